instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue_pkg.sv | 26 ++
 rtl/ifq_storage.sv | 32 +++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// CPU_Defines: shared pipeline types for the fetch path.
//   ExceptinPipeType - exception flags carried alongside an instruction
//   IFQEntryType     - one fetch-queue entry {PC, Instr, ExceptType}
//   IFQ_DEPTH        - fetch-queue depth used by the instantiating top
package CPU_Defines;

  typedef struct packed {
    logic interrupt;
    logic if_adel;
    logic if_tlb_refill;
    logic if_tlb_invalid;
    logic reserved_instr;
    logic syscall;
    logic break_pt;
    logic eret;
  } ExceptinPipeType;

  typedef struct packed {
    logic [31:0]     PC;
    logic [31:0]     Instr;
    ExceptinPipeType ExceptType;
  } IFQEntryType;

  localparam int unsigned IFQ_DEPTH = 4;

endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH x IFQEntryType register array for the fetch queue.
// Ports:
//   clk          - pipeline clock
//   we_i         - write enable
//   waddr_i      - write index
//   wdata_i      - entry to write
//   raddr_i      - read index (asynchronous read)
//   rdata_o      - entry at raddr_i
// Contents are not reset; validity is tracked by the owner's count.
module ifq_storage
  import CPU_Defines::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  IFQEntryType   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output IFQEntryType   rdata_o
);

  IFQEntryType mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order decoupling FIFO between IF and the ID register.
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   flush              - drop all entries and the same-cycle input
//   in_valid/in_ready  - IF handshake; in_pc, in_instr, in_except payload
//   out_valid/out_ready- ID handshake; out_pc, out_instr, out_except payload
//   count              - current occupancy (0..DEPTH)
// Build option: IFQ_BYPASS_EN - when empty, IF input is forwarded straight
// to the outputs and, if ID takes it, never written to storage.
// Invalid outputs are forced to zero so ID latches a NOP bubble.
module instr_fetch_queue
  import CPU_Defines::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  ExceptinPipeType          in_except,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output ExceptinPipeType          out_except,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, bypass, push, pop;
  IFQEntryType   wr_entry, rd_entry, head;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_CNT);

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (~empty & ~flush) | bypass;
  assign pop       = ~empty & ~flush & out_ready;
  // A bypassed entry taken by ID the same cycle never lands in storage.
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);

  assign wr_entry = '{PC: in_pc, Instr: in_instr, ExceptType: in_except};

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    head = '0;
    if (!empty && !flush) head = rd_entry;
    else if (bypass)      head = wr_entry;
  end

  assign out_pc     = head.PC;
  assign out_instr  = head.Instr;
  assign out_except = head.ExceptType;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
`timescale 1ns/1ps
module tb_instr_fetch_queue;
  import CPU_Defines::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  ExceptinPipeType in_except, out_except;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;
  IFQEntryType mq[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_except(in_except),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_except(out_except),
    .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries, checked 2ns after each
  // negedge and advanced to the state the next posedge must produce.
  always begin
    @(negedge clk);
    #2;
    if (resetn && chk_en) begin
      int sz;
      bit byp, ev;
      IFQEntryType h, e;
      sz  = mq.size();
      byp = 0;
`ifdef IFQ_BYPASS_EN
      byp = (sz == 0) && in_valid && !flush;
`endif
      ev = ((sz != 0) && !flush) || byp;
      e  = '{PC: in_pc, Instr: in_instr, ExceptType: in_except};
      h  = '0;
      if (ev) h = (sz != 0) ? mq[0] : e;
      chk("m_out_valid", 32'(out_valid), 32'(ev));
      chk("m_in_ready",  32'(in_ready),  32'(sz < DEPTH));
      chk("m_count",     32'(count),     32'(sz));
      chk("m_out_pc",    out_pc,         h.PC);
      chk("m_out_instr", out_instr,      h.Instr);
      chk("m_out_except", 32'(out_except), 32'(h.ExceptType));
      if (flush) mq.delete();
      else if (!(byp && out_ready)) begin
        if (ev && out_ready && sz != 0) void'(mq.pop_front());
        if (in_valid && sz < DEPTH) mq.push_back(e);
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] pc, input logic [7:0] ex,
                      input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = pc ^ 32'h1234_5678;
    in_except = ExceptinPipeType'(ex);
    out_ready = ordy;
    flush     = fl;
    #3;
  endtask

  initial begin
    logic [31:0] pc;
    resetn = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = 0; in_instr = 0; in_except = '0;
    repeat (2) @(negedge clk);
    resetn = 1;
    chk_en = 1;

    // Reset state
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);

    // Fill to full, 5th push refused, then drain in order
    for (int i = 0; i < 4; i++) step(1, 32'hBFC0_0000 + 32'(4*i), 0, 0, 0);
    step(1, 32'hBFC0_0010, 0, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("drain_pc", out_pc, 32'hBFC0_0000 + 32'(4*i));
      chk("drain_valid", 32'(out_valid), 1);
    end
    step(0, 0, 0, 1, 0);
    chk("drained_valid", 32'(out_valid), 0);
    chk("drained_instr", out_instr, 0);
    chk("drained_count", 32'(count), 0);

    // Streaming push+pop every cycle
    for (int i = 0; i < 6; i++) begin
      pc = 32'h0000_1000 + 32'(4*i);
      step(1, pc, 0, 1, 0);
`ifdef IFQ_BYPASS_EN
      chk("stream_count", 32'(count), 0);
      chk("stream_pc", out_pc, pc);
`else
      if (i > 0) begin
        chk("stream_count", 32'(count), 1);
        chk("stream_pc", out_pc, pc - 32'd4);
      end
`endif
    end
    step(0, 0, 0, 1, 0);

    // Flush with 3 entries plus a same-cycle input
    for (int i = 0; i < 3; i++) step(1, 32'h0000_2000 + 32'(4*i), 0, 0, 0);
    step(1, 32'hDEAD_0000, 0, 0, 1);
    chk("flush_out_valid", 32'(out_valid), 0);
    step(0, 0, 0, 1, 0);
    chk("post_flush_count", 32'(count), 0);
    chk("post_flush_valid", 32'(out_valid), 0);
    step(0, 0, 0, 1, 0);
    chk("post_flush_pc", out_pc, 0);

    // Fetch address error travels with its entry
    step(1, 32'h0000_0003, 8'h40, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("exc_pc", out_pc, 32'h0000_0003);
    chk("exc_flags", 32'(out_except), 32'h40);
    step(0, 0, 0, 1, 0);

    // Wrap-around at count=2
    step(1, 32'h0000_3000, 0, 0, 0);
    step(1, 32'h0000_3004, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h0000_3008 + 32'(4*i), 0, 1, 0);
      chk("wrap_pc", out_pc, 32'h0000_3000 + 32'(4*i));
      chk("wrap_count", 32'(count), 2);
    end
    step(0, 0, 0, 1, 0);
    chk("wrap_tail0", out_pc, 32'h0000_3018);
    step(0, 0, 0, 1, 0);
    chk("wrap_tail1", out_pc, 32'h0000_301C);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 32'h0000_4000 + 32'(4*i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 3);
    resetn = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    mq.delete();
    @(negedge clk);
    resetn = 1;
    #3;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
